// File: rtl/interface_hcsr04.sv
// HC-SR04 ultrasonic ranger controller. It fires a 10 us trigger, times the echo pulse and reports the distance in cm as 3 BCD digits.
// Latency: trigger rises 2 cycles after medir's rising edge is sampled; pronto rises 2 cycles after the synchronized echo falls.
// Backpressure: none. Result is held with pronto=1 until the next medir edge; optional watchdog macro INTERFACE_HCSR04_TIMEOUT_EN.
module interface_hcsr04 #(
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TRIGGER_CYCLES = 500
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  // One shared counter times the trigger pulse and then the per-cm echo slices.
  localparam int CNT_MAX = (CYCLES_PER_CM > TRIGGER_CYCLES) ? CYCLES_PER_CM : TRIGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CM_LAST   = CNT_W'(CYCLES_PER_CM - 1);
  // Half a centimetre of residual rounds up (1471 for the 2941-cycle cm).
  localparam logic [CNT_W-1:0] CM_HALF   = CNT_W'((CYCLES_PER_CM + 1) / 2);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDINDO       = 4'h4,
    ARMAZENA      = 4'h5,
    FINAL         = 4'h6
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
    , TIMEOUT     = 4'hF
`endif
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             medir_q;
  logic             medir_rise;
  logic             echo_s1;
  logic             echo_s2;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      bcd;

  // Saturating BCD increment: decimal carry per digit, sticks at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  assign medir_rise = medir & ~medir_q;
  assign db_estado  = state;

  // Remember last medir sample for edge detection; 2-FF synchronizer for the async echo.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      medir_q <= 1'b0;
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
    end else begin
      medir_q <= medir;
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
    end
  end

`ifdef INTERFACE_HCSR04_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;

  // Watchdog runs only while waiting for echo and restarts on every other state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ESPERA_ECHO) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INICIAL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; medir edges only matter in INICIAL and FINAL.
  always_comb begin
    next_state = state;
    case (state)
      INICIAL:       if (medir_rise) next_state = PREPARA;
      PREPARA:       next_state = ENVIA_TRIGGER;
      ENVIA_TRIGGER: if (cnt == TRIG_LAST) next_state = ESPERA_ECHO;
      ESPERA_ECHO: begin
        // Level check: an echo already high on entry is accepted at once.
        if (echo_s2) begin
          next_state = MEDINDO;
        end
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          next_state = TIMEOUT;
        end
`endif
      end
      MEDINDO:       if (!echo_s2) next_state = ARMAZENA;
      ARMAZENA:      next_state = FINAL;
      FINAL:         if (medir_rise) next_state = PREPARA;
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
      TIMEOUT:       next_state = FINAL;
`endif
      default:       next_state = INICIAL;
    endcase
  end

  // Cycle counter and BCD distance counter; every synchronized echo-high cycle is counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      bcd <= 12'h000;
    end else begin
      case (state)
        PREPARA: begin
          cnt <= '0;
          bcd <= 12'h000;
        end
        ENVIA_TRIGGER: begin
          // Wraps back to 0 on exit so the echo timing starts clean.
          cnt <= (cnt == TRIG_LAST) ? '0 : cnt + CNT_W'(1);
        end
        ESPERA_ECHO, MEDINDO: begin
          if (echo_s2) begin
            if (cnt == CM_LAST) begin
              cnt <= '0;
              bcd <= bcd_inc(bcd);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt <= cnt;
          bcd <= bcd;
        end
      endcase
    end
  end

  // Result register: loaded only in ARMAZENA, with round-half-up on the residual.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      medida <= 12'h000;
    end else if (state == ARMAZENA) begin
      medida <= (cnt >= CM_HALF) ? bcd_inc(bcd) : bcd;
    end
  end

  // Registered trigger and pronto outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trigger <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      trigger <= (state == ENVIA_TRIGGER);
      pronto  <= (next_state == FINAL);
    end
  end

endmodule

// File: tb/tb_interface_hcsr04.sv
// Directed bench for interface_hcsr04 with a scaled 11-cycle centimetre.
// Table-driven echo widths plus hand-written corner sequences.
// Each comparison prints on a mismatch; one summary line at the end.
module tb_interface_hcsr04;

  localparam int CM   = 11;
  localparam int TRIG = 500;
  localparam int TO   = 3000;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic [3:0]  db_estado;

  int total;
  int bad;

  interface_hcsr04 #(
    .CYCLES_PER_CM  (CM),
    .TRIGGER_CYCLES (TRIG)
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .medida    (medida),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  typedef struct {
    int          echo_cyc;
    int          gap;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse medir for 5 cycles, verify trigger latency/width, return once trigger is low.
  task automatic start_meas(input logic [11:0] prev, input logic [3:0] exp_db);
    int n;
    int guard;
    medir = 1'b1;
    tick(); check("st_prepara", db_estado, 4'h1);
    tick(); check("st_envia", db_estado, 4'h2); check("trig_latency", trigger, 1'b0);
    tick(); check("trig_rise", trigger, 1'b1); check("medida_hold", medida, prev);
    check("pronto_cleared", pronto, 1'b0);
    n = 1;
    guard = 0;
    while (trigger && guard < 1000) begin
      tick();
      guard++;
      if (guard == 2) medir = 1'b0;
      if (trigger) n++;
    end
    medir = 1'b0;
    check("trig_bound", guard < 1000, 1'b1);
    check("trig_width", n, TRIG);
    check("st_after_trig", db_estado, exp_db);
  endtask

  // Echo already lowered: check ARMAZENA/FINAL timing and result.
  task automatic finish_check(input logic [11:0] exp);
    tick(); tick(); tick();
    check("st_armazena", db_estado, 4'h5);
    check("pronto_early", pronto, 1'b0);
    tick();
    check("st_final", db_estado, 4'h6);
    check("pronto_rise", pronto, 1'b1);
    check("medida", medida, exp);
  endtask

  task automatic echo_pulse(input int n, input bit poke, input logic [11:0] exp);
    echo = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (poke && i == 10) medir = 1'b1;
      if (poke && i == 13) medir = 1'b0;
      if (poke && i == 14) check("poke_ignored", db_estado, 4'h4);
    end
    echo = 1'b0;
    finish_check(exp);
  endtask

  initial begin
    logic [11:0] prev;
    bit          seen;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    medir = 1'b0;
    echo  = 1'b0;

    vecs[0]  = '{1100,  20, 12'h100};
    vecs[1]  = '{1105,  20, 12'h100};
    vecs[2]  = '{1106,   5, 12'h101};
    vecs[3]  = '{1,     20, 12'h000};
    vecs[4]  = '{5,      3, 12'h000};
    vecs[5]  = '{6,     20, 12'h001};
    vecs[6]  = '{16,    20, 12'h001};
    vecs[7]  = '{17,    20, 12'h002};
    vecs[8]  = '{814,   20, 12'h074};
    vecs[9]  = '{820,   20, 12'h075};
    vecs[10] = '{1095,   0, 12'h100};
    vecs[11] = '{215,   20, 12'h020};
    vecs[12] = '{10812, 20, 12'h983};
    vecs[13] = '{10995, 20, 12'h999};
    vecs[14] = '{11000, 20, 12'h999};

    // Reset held for 2 us.
    repeat (50) tick();
    check("rst_trigger", trigger, 1'b0);
    check("rst_pronto", pronto, 1'b0);
    check("rst_medida", medida, 12'h000);
    check("rst_state", db_estado, 4'h0);
    repeat (50) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("idle_trigger", trigger, 1'b0);
    check("idle_pronto", pronto, 1'b0);
    check("idle_medida", medida, 12'h000);
    check("idle_state", db_estado, 4'h0);

    // Echo width table.
    prev = 12'h000;
    for (int i = 0; i < 15; i++) begin
      start_meas(prev, 4'h3);
      repeat (vecs[i].gap) tick();
      check("st_espera", db_estado, 4'h3);
      echo_pulse(vecs[i].echo_cyc, 1'b0, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // medir pulsed while measuring is ignored; FINAL holds until next medir.
    start_meas(prev, 4'h3);
    repeat (20) tick();
    echo_pulse(220, 1'b1, 12'h020);
    repeat (50) tick();
    check("final_hold_pronto", pronto, 1'b1);
    check("final_hold_state", db_estado, 4'h6);
    check("final_hold_medida", medida, 12'h020);
    prev = 12'h020;

    // Echo already high when ESPERA_ECHO is entered: 30 more cycles -> 33 counted.
    echo = 1'b1;
    start_meas(prev, 4'h4);
    repeat (30) tick();
    echo = 1'b0;
    finish_check(12'h003);
    prev = 12'h003;

    // Reset during trigger aborts at once.
    medir = 1'b1;
    tick(); tick(); tick();
    check("pre_abort_trigger", trigger, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_trig_trigger", trigger, 1'b0);
    check("abort_trig_state", db_estado, 4'h0);
    check("abort_trig_medida", medida, 12'h000);
    medir = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    prev = 12'h000;

    // Build a non-zero result, then reset during echo.
    start_meas(prev, 4'h3);
    repeat (5) tick();
    echo_pulse(77, 1'b0, 12'h007);
    prev = 12'h007;
    start_meas(prev, 4'h3);
    echo = 1'b1;
    repeat (40) tick();
    check("pre_abort_state", db_estado, 4'h4);
    reset = 1'b0;
    #1;
    check("abort_echo_state", db_estado, 4'h0);
    check("abort_echo_pronto", pronto, 1'b0);
    check("abort_echo_medida", medida, 12'h000);
    echo = 1'b0;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("after_abort_state", db_estado, 4'h0);
    check("after_abort_pronto", pronto, 1'b0);
    prev = 12'h000;

    // Missing echo.
    start_meas(prev, 4'h3);
`ifdef INTERFACE_HCSR04_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < TO + 100 && !seen; i++) begin
      tick();
      if (db_estado == 4'hF) seen = 1'b1;
    end
    check("timeout_seen", seen, 1'b1);
    tick();
    check("timeout_final", db_estado, 4'h6);
    check("timeout_pronto", pronto, 1'b1);
    check("timeout_medida", medida, prev);
`else
    seen = 1'b0;
    for (int i = 0; i < TO + 100; i++) begin
      tick();
      if (db_estado != 4'h3) seen = 1'b1;
    end
    check("no_timeout_left", seen, 1'b0);
    check("no_timeout_pronto", pronto, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interface_hcsr04.md
INTERFACE_HCSR04 -- requirements
Module: interface_hcsr04

Interface
REQ-001 clock  input  1  system clock, 50 MHz (20 ns), all logic on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-003 medir  input  1  measurement request; a rising edge (0->1, sampled on clock) starts one measurement.
REQ-004 echo  input  1  HC-SR04 echo pulse, asynchronous; passed through a 2-FF synchronizer before use.
REQ-005 trigger  output  1  HC-SR04 trigger pulse, registered.
REQ-006 medida  output  12  distance in cm as 3 BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units; registered.
REQ-007 pronto  output  1  measurement complete, registered.
REQ-008 db_estado  output  4  current FSM state code, for debug.

Function
REQ-009 FSM states/codes: INICIAL=0, PREPARA=1, ENVIA_TRIGGER=2, ESPERA_ECHO=3, MEDINDO=4, ARMAZENA=5, FINAL=6, TIMEOUT=F (macro only); db_estado shall equal the current code.
REQ-010 INICIAL: trigger=0, pronto=0; medir rising edge -> PREPARA.
REQ-011 PREPARA (1 cycle): clear the cycle counter and the BCD distance counter -> ENVIA_TRIGGER.
REQ-012 ENVIA_TRIGGER: trigger=1 for exactly 500 cycles (10 us), then -> ESPERA_ECHO.
REQ-013 ESPERA_ECHO: trigger=0; synchronized echo=1 -> MEDINDO.
REQ-014 MEDINDO: count clock cycles while echo=1; echo falling -> ARMAZENA.
REQ-015 Conversion: 1 cm = 2941 cycles (58.82 us).
  - cycle counter runs 0..2940 and wraps.
  - BCD counter increments by 1 on each wrap.
  - rounding: on echo fall, if residual count >= 1471, add 1 cm.
  - result: medida = round(echo_cycles / 2941).
REQ-016 BCD counter: decimal carry per digit (9->0 carry); saturates at 999 (no wrap to 000).
REQ-017 ARMAZENA (1 cycle): load rounded BCD value into medida register -> FINAL.
REQ-018 FINAL: pronto=1, held until next medir rising edge, which clears pronto and -> PREPARA.
REQ-019 medida holds its value between measurements; it changes only in ARMAZENA.
REQ-020 medir edges in states PREPARA..ARMAZENA are ignored.
REQ-021 Echo high already at entry to ESPERA_ECHO is accepted immediately (no edge requirement).
REQ-022 Latency: trigger rises 2 cycles after the clock edge sampling medir rising; pronto rises 2 cycles after synchronized echo falls (+2 synchronizer cycles).

Reset
REQ-023 reset=0 asynchronously forces:
  - state INICIAL, db_estado=0;
  - trigger=0, pronto=0, medida=12'h000;
  - all counters and synchronizer FFs 0.
REQ-024 Reset asserted mid-measurement (including during trigger) aborts immediately; no partial medida is stored.

Configuration
REQ-025 Macro INTERFACE_HCSR04_TIMEOUT_EN.
  - Defined: a 2,000,000-cycle (40 ms) watchdog runs in ESPERA_ECHO; on expiry -> TIMEOUT (db_estado=F, 1 cycle), then -> FINAL with pronto=1 and medida unchanged.
  - Undefined: no watchdog; ESPERA_ECHO waits indefinitely; code F is never produced.

Verification
REQ-026 Reset low 2 us, then high -> trigger=0, pronto=0, medida=000, db_estado=0.
REQ-027 medir pulse 5 cycles -> trigger high for exactly 500 cycles; echo 5882 us after a 400 us gap -> pronto=1, medida=12'h100; echo 5899 us -> 12'h100.
REQ-028 Echo widths -> required medida:
  - 4353 us -> 12'h074; 4399 us -> 12'h075;
  - 6000 us -> 12'h102; 10000 us -> 12'h170;
  - 15000 us -> 12'h255; 20000 us -> 12'h340;
  - 57820 us -> 12'h983; 58820 us -> 12'h999 (saturated).
REQ-029 medir pulsed again during MEDINDO -> ignored, measurement result unchanged; pronto stays 1 after FINAL until the next medir.
REQ-030 Reset low during echo -> immediate INICIAL, medida keeps 000/previous-reset value, pronto=0.
REQ-031 With INTERFACE_HCSR04_TIMEOUT_EN: no echo for 40 ms -> db_estado=F, then pronto=1 with medida unchanged.
